// File: rtl/instruction_fetch_sequencer.sv
// Fetch/sequence stage for the 8-bit processor: PC, IR, imem handshake, execute strobe, HALT and fetch timeout.
// Optional build macro JUMP_REL_EN turns opcode 4'b0101 into a PC-relative jump (JMPR) resolved in EXEC.
module instruction_fetch_sequencer #(
    parameter int PC_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [7:0]          imem_data,
    output logic [3:0]          opcode,
    output logic [1:0]          ra,
    output logic [1:0]          rb,
    input  logic                cu_load_enable,
    input  logic                mem_done,
    output logic                exec_en,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0]          TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [PC_WIDTH-1:0] PC_ONE   = PC_WIDTH'(1);
    localparam logic [3:0]          OP_HALT  = 4'b1111;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [7:0]          tmo_q, tmo_d;
    logic                is_jmpr;

`ifdef JUMP_REL_EN
    logic [PC_WIDTH-1:0] jmp_offset;
    assign is_jmpr    = (ir_q[7:4] == 4'b0101);
    assign jmp_offset = {{(PC_WIDTH-4){ir_q[3]}}, ir_q[3:0]};
`else
    assign is_jmpr = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        tmo_d    = tmo_q;
        imem_req = 1'b0;
        exec_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = (ir_q[7:4] == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (is_jmpr) begin
`ifdef JUMP_REL_EN
                    pc_d = pc_q + jmp_offset;
`endif
                    state_d = S_FETCH;
                end else begin
                    exec_en = 1'b1;
                    if (cu_load_enable) begin
                        state_d = S_MEM;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_MEM: begin
                if (mem_done) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        // The wait counter restarts from zero whenever a new state is entered.
        if (state_d != state_q) tmo_d = 8'd0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= 8'h00;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            tmo_q   <= tmo_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = ir_q[7:4];
    assign ra        = ir_q[3:2];
    assign rb        = ir_q[1:0];
    assign halted    = (state_q == S_HALT);
    assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Self-checking bench for instruction_fetch_sequencer: imem responder, exec_en scoreboard, directed steps.
// Build with JUMP_REL_EN defined or not; the jump expectations follow the same macro.
module tb_instruction_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] imem_addr;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [3:0] opcode;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       cu_load_enable;
    logic       mem_done;
    logic       exec_en;
    logic [7:0] pc;
    logic       halted;
    logic       fault;

    instruction_fetch_sequencer #(
        .PC_WIDTH      (8),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .opcode        (opcode),
        .ra            (ra),
        .rb            (rb),
        .cu_load_enable(cu_load_enable),
        .mem_done      (mem_done),
        .exec_en       (exec_en),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault)
    );

    typedef struct {
        logic [7:0] pc;
        logic [3:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        int         cyc;   // expected cycle after run, or -1 when not timed
    } exp_t;

    exp_t       sb[$];
    logic [7:0] imem[256];
    int         checks;
    int         errors;
    int         cyc;
    int         cyc_base;
    int         ack_delay;
    bit         ack_enable;
    int         ack_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic push_exp(input logic [7:0] p, input logic [7:0] instr, input int c);
        exp_t e;
        e.pc  = p;
        e.op  = instr[7:4];
        e.ra  = instr[3:2];
        e.rb  = instr[1:0];
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        run            = 1'b0;
        cu_load_enable = 1'b0;
        mem_done       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) timeout_fail(tag);
    endtask

    task automatic wait_halted(input string tag, input int budget);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (halted !== 1'b1) timeout_fail(tag);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    // Instruction memory: acks ack_delay cycles after req first rises, checks the address holds while waiting.
    initial begin
        int         wait_cnt;
        logic [7:0] req_addr;
        wait_cnt  = 0;
        req_addr  = 8'h00;
        imem_ack  = 1'b0;
        imem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && ack_enable) begin
                if (wait_cnt == 0) req_addr = imem_addr;
                else               check("imem_addr stable", imem_addr, req_addr);
                if (wait_cnt >= ack_delay) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[imem_addr];
                    ack_count++;
                end else begin
                    imem_ack = 1'b0;
                end
                wait_cnt++;
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard consumer: every exec_en strobe must match the next expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exec_en === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected exec_en: observed pc 'h%0h opcode 'h%0h expected no strobe", pc, opcode);
                end else begin
                    e = sb.pop_front();
                    check("exec pc", pc, e.pc);
                    check("exec opcode", opcode, e.op);
                    check("exec ra", ra, e.ra);
                    check("exec rb", rb, e.rb);
                    if (e.cyc >= 0) check("exec cycle", cyc - cyc_base, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        logic [7:0] jmp_target;
        checks         = 0;
        errors         = 0;
        cyc_base       = 0;
        ack_delay      = 0;
        ack_enable     = 1'b1;
        ack_count      = 0;
        rst            = 1'b1;
        run            = 1'b0;
        cu_load_enable = 1'b0;
        mem_done       = 1'b0;
        clear_imem();

        // Reset state, then IDLE holds while run is low.
        repeat (2) @(negedge clk);
        check("reset imem_req", imem_req, 1'b0);
        check("reset exec_en", exec_en, 1'b0);
        check("reset halted", halted, 1'b0);
        check("reset fault", fault, 1'b0);
        check("reset pc", pc, 8'h00);
        check("reset imem_addr", imem_addr, 8'h00);
        check("reset ir", {opcode, ra, rb}, 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle imem_req", imem_req, 1'b0);
        check("idle pc", pc, 8'h00);

        // Zero-wait program {31, 04, F0}: exec at cycles 3 and 6, HALT entered at cycle 9 with pc=2.
        imem[0] = 8'h31;
        imem[1] = 8'h04;
        imem[2] = 8'hF0;
        push_exp(8'h00, 8'h31, 3);
        push_exp(8'h01, 8'h04, 6);
        run      = 1'b1;
        cyc_base = cyc;
        repeat (8) @(negedge clk);
        check("prog1 decode halt opcode", opcode, 4'hF);
        check("prog1 halted before halt state", halted, 1'b0);
        @(negedge clk);
        check("prog1 halted", halted, 1'b1);
        check("prog1 halt pc", pc, 8'h02);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("prog1 halted sticky", halted, 1'b1);
        check("prog1 halt imem_req", imem_req, 1'b0);
        check("prog1 scoreboard drained", sb.size(), 0);

        // imem ack delayed by 4 cycles: one IR load per fetch, single exec.
        do_reset();
        clear_imem();
        imem[0]   = 8'h4B;
        imem[1]   = 8'hF0;
        ack_delay = 4;
        ack_count = 0;
        push_exp(8'h00, 8'h4B, -1);
        run = 1'b1;
        wait_halted("prog2 halt", 60);
        check("prog2 halt pc", pc, 8'h01);
        check("prog2 ack count", ack_count, 2);
        check("prog2 scoreboard drained", sb.size(), 0);

        // LOAD with mem_done after 3 MEM cycles: pc advances only after mem_done.
        do_reset();
        clear_imem();
        imem[0]        = 8'h86;
        imem[1]        = 8'hF0;
        ack_delay      = 0;
        cu_load_enable = 1'b1;
        push_exp(8'h00, 8'h86, -1);
        run = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (exec_en !== 1'b1 && n < 20);
        if (exec_en !== 1'b1) timeout_fail("prog3 exec");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("prog3 mem pc held", pc, 8'h00);
            check("prog3 mem imem_req", imem_req, 1'b0);
            check("prog3 mem exec_en", exec_en, 1'b0);
            if (i == 2) mem_done = 1'b1;
        end
        @(negedge clk);
        mem_done = 1'b0;
        check("prog3 pc after mem_done", pc, 8'h01);
        check("prog3 refetch imem_req", imem_req, 1'b1);
        wait_halted("prog3 halt", 20);
        check("prog3 halt pc", pc, 8'h01);
        cu_load_enable = 1'b0;

        // No ack ever: 15 FETCH cycles, then sticky FAULT with imem_req low.
        do_reset();
        ack_enable = 1'b0;
        run        = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            check("timeout fault early", fault, 1'b0);
            check("timeout imem_req held", imem_req, 1'b1);
            @(negedge clk);
        end
        check("timeout fault", fault, 1'b1);
        check("timeout imem_req dropped", imem_req, 1'b0);
        ack_enable = 1'b1;
        run        = 1'b0;
        repeat (5) @(negedge clk);
        check("fault sticky", fault, 1'b1);
        check("fault imem_req", imem_req, 1'b0);
        check("fault pc", pc, 8'h00);

        // 257 no-memory instructions: pc runs 00..FF and wraps to 00.
        do_reset();
        clear_imem();
        ack_delay = 0;
        for (int i = 0; i < 257; i++) push_exp(8'(i), 8'h00, -1);
        run = 1'b1;
        wait_drain("wrap drain", 1000);
        check("wrap pc", pc, 8'h00);

        // rst while an ack is in flight: next cycle imem_req=0 and pc=0, aborted fetch never executes.
        do_reset();
        ack_delay = 2;
        push_exp(8'h00, 8'h00, -1);
        push_exp(8'h01, 8'h00, -1);
        run = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(pc === 8'h02 && imem_ack === 1'b1) && n < 40);
        if (!(pc === 8'h02 && imem_ack === 1'b1)) timeout_fail("rst mid-fetch setup");
        rst = 1'b1;
        @(negedge clk);
        check("rst mid-fetch imem_req", imem_req, 1'b0);
        check("rst mid-fetch pc", pc, 8'h00);
        check("rst mid-fetch exec_en", exec_en, 1'b0);
        rst = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("rst mid-fetch idle imem_req", imem_req, 1'b0);
        check("rst mid-fetch idle pc", pc, 8'h00);
        check("rst mid-fetch scoreboard", sb.size(), 0);

        // Opcode 5 at pc 10: JMPR by -2 when the macro is built in, otherwise an ordinary instruction.
        do_reset();
        clear_imem();
        imem[8'h10] = 8'h5E;
        ack_delay   = 0;
        for (int i = 0; i < 16; i++) push_exp(8'(i), 8'h00, -1);
`ifdef JUMP_REL_EN
        jmp_target = 8'h0E;
`else
        jmp_target = 8'h11;
        push_exp(8'h10, 8'h5E, -1);
`endif
        run = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req === 1'b1 && imem_addr === 8'h10) && n < 100);
        if (imem_addr !== 8'h10) timeout_fail("jump reach 10");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (imem_req === 1'b1 && n < 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (imem_req !== 1'b1 && n < 10);
        check("jump next imem_addr", imem_addr, jmp_target);
        check("jump scoreboard drained", sb.size(), 0);
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
